// File: rtl/c_mem.sv
// Coefficient memory: 256 x 20-bit register-file RAM with a synchronous write port
// and a combinational read port. CEN/WEN are active-low.
module c_mem (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CEN,
   input  logic        WEN,
   input  logic [7:0]  CADDR,
   input  logic [19:0] D,
   input  logic [7:0]  A0,
   output logic [19:0] Q0
);

   localparam int unsigned DW    = 20;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   // Reset clears every word and takes priority over a write in the same cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (!CEN && !WEN) begin
         mem[CADDR] <= D;
      end
   end

   always_comb begin
      Q0 = '0;
      if (!CEN) begin
         Q0 = mem[A0];
      end
   end

endmodule

// File: tb/tb_c_mem.sv
// Scoreboard bench for c_mem: stimulus pushes expected read data, a monitor
// samples Q0 shortly before each rising edge and compares.
module tb_c_mem;

   logic        clk;
   logic        rst_n;
   logic        CEN;
   logic        WEN;
   logic [7:0]  CADDR;
   logic [19:0] D;
   logic [7:0]  A0;
   logic [19:0] Q0;

   typedef struct {
      string       nm;
      logic [19:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [19:0] mdl [256];
   bit          chk;
   bit          done;
   int          checks;
   int          errors;

   c_mem dut (
      .clk   (clk),
      .rst_n (rst_n),
      .CEN   (CEN),
      .WEN   (WEN),
      .CADDR (CADDR),
      .D     (D),
      .A0    (A0),
      .Q0    (Q0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 ns after the falling edge; the monitor samples 2 ns before the rising edge.
   task automatic drive(input logic r, input logic cen, input logic wen,
                        input logic [7:0] ca, input logic [19:0] dd, input logic [7:0] a,
                        input bit c, input logic [19:0] e, input string nm);
      @(negedge clk);
      #1;
      rst_n = r;
      CEN   = cen;
      WEN   = wen;
      CADDR = ca;
      D     = dd;
      A0    = a;
      chk   = c;
      if (c) exp_q.push_back('{nm, e});
      if (!r) begin
         for (int i = 0; i < 256; i++) mdl[i] = '0;
      end else if (!cen && !wen) begin
         mdl[ca] = dd;
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (chk) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow: Q0=%h with no expected entry", Q0);
            end else begin
               e = exp_q.pop_front();
               if (Q0 !== e.val) begin
                  errors++;
                  $display("FAIL %s: A0=%h CEN=%b got Q0=%h expected %h", e.nm, A0, CEN, Q0, e.val);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      if (!done) begin
         $display("FAIL watchdog: simulation did not complete in time");
         $fatal(1, "timeout");
      end
   end

   initial begin : stim
      logic [7:0]  a;
      logic [19:0] r;
      done   = 1'b0;
      checks = 0;
      errors = 0;
      chk    = 1'b0;
      rst_n  = 1'b0;
      CEN    = 1'b1;
      WEN    = 1'b1;
      CADDR  = '0;
      D      = '0;
      A0     = '0;

      // Reset held for two edges, then sweep every address
      drive(1'b0, 1'b1, 1'b1, 8'h00, 20'h0, 8'h00, 1'b0, 20'h0, "");
      drive(1'b0, 1'b1, 1'b1, 8'h00, 20'h0, 8'h00, 1'b0, 20'h0, "");
      for (int i = 0; i < 256; i++)
         drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'(i), 1'b1, 20'h00000, "reset_sweep");

      // Full fill with random data, then random readback against the model
      for (int i = 0; i < 256; i++) begin
         r = 20'($urandom);
         drive(1'b1, 1'b0, 1'b0, 8'(i), r, 8'h00, 1'b0, 20'h0, "");
      end
      for (int i = 0; i < 256; i++) begin
         a = 8'($urandom_range(0, 255));
         drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, a, 1'b1, mdl[a], "fill_readback");
      end

      // Write inhibit
      drive(1'b1, 1'b0, 1'b0, 8'h10, 20'hABCDE, 8'h10, 1'b0, 20'h0, "");
      drive(1'b1, 1'b0, 1'b1, 8'h10, 20'h12345, 8'h10, 1'b1, 20'hABCDE, "inhibit_wen");
      drive(1'b1, 1'b1, 1'b0, 8'h10, 20'h12345, 8'h10, 1'b1, 20'h00000, "inhibit_cen_q0");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'h10, 1'b1, 20'hABCDE, "inhibit_readback");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 20'h0, 8'h10, 1'b1, 20'h00000, "cen_high_q0");

      // Read-during-write to the same address
      drive(1'b1, 1'b0, 1'b0, 8'h05, 20'h00001, 8'h00, 1'b0, 20'h0, "");
      drive(1'b1, 1'b0, 1'b0, 8'h05, 20'hFFFFF, 8'h05, 1'b1, 20'h00001, "rdw_before_edge");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'h05, 1'b1, 20'hFFFFF, "rdw_after_edge");

      // Address boundaries
      drive(1'b1, 1'b0, 1'b0, 8'h00, 20'hFFFFF, 8'h00, 1'b0, 20'h0, "");
      drive(1'b1, 1'b0, 1'b0, 8'hFF, 20'h80001, 8'h00, 1'b1, 20'hFFFFF, "boundary_addr0");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'hFF, 1'b1, 20'h80001, "boundary_addr255");

      // Reset wins over a simultaneous write
      drive(1'b0, 1'b0, 1'b0, 8'hFF, 20'h12345, 8'hFF, 1'b1, 20'h80001, "pre_reset_255");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'hFF, 1'b1, 20'h00000, "reset_priority_255");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'h00, 1'b1, 20'h00000, "reset_priority_0");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'h10, 1'b1, 20'h00000, "reset_priority_10");

      // Writes resume right after reset
      drive(1'b1, 1'b0, 1'b0, 8'h7F, 20'h5A5A5, 8'h00, 1'b0, 20'h0, "");
      drive(1'b1, 1'b0, 1'b1, 8'h00, 20'h0, 8'h7F, 1'b1, 20'h5A5A5, "post_reset_write");

      drive(1'b1, 1'b1, 1'b1, 8'h00, 20'h0, 8'h00, 1'b0, 20'h0, "");
      drive(1'b1, 1'b1, 1'b1, 8'h00, 20'h0, 8'h00, 1'b0, 20'h0, "");

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
